// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for a 5-stage pipeline
// Control outputs are combinational; state and saturating counters are registered.
module pipeline_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              pipe_hold_o,
  output logic              mem_wb_bubble_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  wait_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic lu, mw, active;
  logic pri_wait, pri_stall, pri_flush;

  assign lu = ex_memread_i && (ex_rd_i != '0) &&
              ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
  assign mw = mem_req_i & ~mem_ready_i;

  assign active    = (state_q == RUN) || (state_q == MEM_WAIT);
  assign pri_wait  = active & mw;
  assign pri_stall = active & ~mw & lu;
  assign pri_flush = active & ~mw & ~lu & id_branch_taken_i;

  // Idle and memory freeze look identical to the datapath: nothing advances.
  assign pc_write_o      = active & ~mw & ~lu;
  assign if_id_write_o   = active & ~mw & ~lu;
  assign if_id_flush_o   = pri_flush;
  assign id_ex_bubble_o  = pri_stall;
  assign pipe_hold_o     = ~active | mw;
  assign mem_wb_bubble_o = ~active | mw;

  assign state_o     = state_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
  assign wait_cnt_o  = wait_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_i) state_d = RUN;
      RUN: begin
        if (mw)            state_d = MEM_WAIT;
        else if (!start_i) state_d = IDLE;
      end
      MEM_WAIT: if (mem_ready_i) state_d = start_i ? RUN : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_d = sat_inc(stall_q, pri_stall);
    flush_d = sat_inc(flush_q, pri_flush);
    wait_d  = sat_inc(wait_q, pri_wait);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
// Two instances (32-bit and 2-bit counters) share stimulus; a reference model feeds a queue.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic       id_use_rs2_i = 1'b0, ex_memread_i = 1'b0, id_branch_taken_i = 1'b0;
  logic       mem_req_i = 1'b0, mem_ready_i = 1'b1;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_hold, s_mem_wb_bubble;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.CNT_W(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .id_branch_taken_i(id_branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
    .id_ex_bubble_o(id_ex_bubble), .pipe_hold_o(pipe_hold), .mem_wb_bubble_o(mem_wb_bubble),
    .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .wait_cnt_o(wait_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .REG_AW(5)) dut_small (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .id_branch_taken_i(id_branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write), .if_id_flush_o(s_if_id_flush),
    .id_ex_bubble_o(s_id_ex_bubble), .pipe_hold_o(s_pipe_hold), .mem_wb_bubble_o(s_mem_wb_bubble),
    .state_o(s_state), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .wait_cnt_o(s_wait_cnt)
  );

  typedef struct {
    logic [5:0] ctrl;
    int         st;
    longint     stall, flush, wt;
    longint     s_stall, s_flush, s_wt;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     done = 1'b0;

  // Reference model: pipeline mode (0 idle,1 run,2 waiting) plus plain integer counters.
  int     m_st = 0;
  longint m_stall = 0, m_flush = 0, m_wt = 0;
  longint m_sstall = 0, m_sflush = 0, m_swt = 0;
  localparam longint MAX32 = 64'd4294967295;
  localparam longint MAX2  = 3;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  function automatic longint bump(input longint v, input bit en, input longint mx);
    return (en && v < mx) ? v + 1 : v;
  endfunction

  task automatic drive(input bit r, input bit s, input int rs1, input int rs2, input bit u2,
                       input bit mr, input int rd, input bit br, input bit rq, input bit rdy);
    bit   lu, mw;
    int   cat;
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = r; start_i = s; id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2); id_use_rs2_i = u2;
    ex_memread_i = mr; ex_rd_i = 5'(rd); id_branch_taken_i = br; mem_req_i = rq; mem_ready_i = rdy;
    lu = mr && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
    mw = rq && !rdy;
    // cat: 0 idle, 1 freeze, 2 load-use, 3 flush, 4 advance
    if (m_st == 0)  cat = 0;
    else if (mw)    cat = 1;
    else if (lu)    cat = 2;
    else if (br)    cat = 3;
    else            cat = 4;
    e.ctrl = {cat >= 3, cat >= 3, cat == 3, cat == 2, cat <= 1, cat <= 1};
    e.st = m_st;
    e.stall = m_stall; e.flush = m_flush; e.wt = m_wt;
    e.s_stall = m_sstall; e.s_flush = m_sflush; e.s_wt = m_swt;
    exp_q.push_back(e);
    if (r) begin
      m_st = 0; m_stall = 0; m_flush = 0; m_wt = 0; m_sstall = 0; m_sflush = 0; m_swt = 0;
    end else begin
      m_stall  = bump(m_stall, cat == 2, MAX32);
      m_flush  = bump(m_flush, cat == 3, MAX32);
      m_wt     = bump(m_wt, cat == 1, MAX32);
      m_sstall = bump(m_sstall, cat == 2, MAX2);
      m_sflush = bump(m_sflush, cat == 3, MAX2);
      m_swt    = bump(m_swt, cat == 1, MAX2);
      if (m_st == 0)      m_st = s ? 1 : 0;
      else if (m_st == 1) m_st = mw ? 2 : (s ? 1 : 0);
      else                m_st = rdy ? (s ? 1 : 0) : 2;
    end
  endtask

  task automatic plain(input bit s);
    drive(0, s, 1, 2, 1, 0, 0, 0, 0, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ctrl", {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble}, e.ctrl);
        chk("state", state, e.st);
        chk("stall_cnt", stall_cnt, e.stall);
        chk("flush_cnt", flush_cnt, e.flush);
        chk("wait_cnt", wait_cnt, e.wt);
        chk("small_ctrl", {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_hold, s_mem_wb_bubble}, e.ctrl);
        chk("small_state", s_state, e.st);
        chk("small_stall_cnt", s_stall_cnt, e.s_stall);
        chk("small_flush_cnt", s_flush_cnt, e.s_flush);
        chk("small_wait_cnt", s_wait_cnt, e.s_wt);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    plain(1);
    plain(1);
    // load-use through rs2, then same with rd=x0
    drive(0, 1, 7, 5, 1, 1, 5, 0, 0, 1);
    drive(0, 1, 7, 5, 1, 1, 0, 0, 0, 1);
    // taken branch alone, then with a load-use hazard
    drive(0, 1, 3, 4, 1, 0, 0, 1, 0, 1);
    drive(0, 1, 3, 4, 0, 1, 3, 1, 0, 1);
    // memory wait with concurrent load-use
    drive(0, 1, 6, 0, 0, 1, 6, 0, 1, 0);
    drive(0, 1, 6, 0, 0, 1, 6, 1, 1, 0);
    drive(0, 1, 6, 0, 0, 1, 6, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    plain(1);
    // stop mid-wait
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    plain(0);
    plain(0);
    // five stalls saturate the 2-bit counter
    plain(1);
    for (int i = 0; i < 5; i++) drive(0, 1, 9, 0, 0, 1, 9, 0, 0, 1);
    // reset while waiting
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    plain(0);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
    end
    @(negedge clk_i);
    @(posedge clk_i);
    chk("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout at %0t: actual=running required=finished", $time);
      $fatal(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Combines three things: load-use hazard detection, flush on a taken branch resolved in ID, and freezing of the whole pipeline for a multi-cycle data memory access (mem_ready handshake).
- Gates pipeline progress on start_i.
- Keeps saturating stall, flush and memory-wait counters that the CPU testbench reads directly.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_AW, 5, register-index width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  run enable from the top level.
- id_rs1_i  input  REG_AW  rs1 of the instruction in ID.
- id_rs2_i  input  REG_AW  rs2 of the instruction in ID.
- id_use_rs2_i  input  1  the ID instruction reads rs2 (R-type, S-type, branch).
- ex_memread_i  input  1  MemRead of ID_EX.
- ex_rd_i  input  REG_AW  rd of ID_EX.
- id_branch_taken_i  input  1  the branch in ID is resolved taken.
- mem_req_i  input  1  EX_MEM MemRead or MemWrite is active.
- mem_ready_i  input  1  data memory completes its access this cycle.
- pc_write_o  output  1  PC register write enable.
- if_id_write_o  output  1  IF_ID write enable.
- if_id_flush_o  output  1  clear IF_ID to NOP on the next edge.
- id_ex_bubble_o  output  1  load zeroed control into ID_EX.
- pipe_hold_o  output  1  ID_EX and EX_MEM hold their values.
- mem_wb_bubble_o  output  1  load zeroed control into MEM_WB.
- state_o  output  2  FSM state (IDLE=0, RUN=1, MEM_WAIT=2).
- stall_cnt_o  output  CNT_W  load-use stall cycles.
- flush_cnt_o  output  CNT_W  flush cycles.
- wait_cnt_o  output  CNT_W  memory-wait cycles.

Behaviour:
- Reset (rst_i=1 at a posedge):
  - state goes to IDLE.
  - All counters go to 0.
  - Reset overrides every other input, including a reset arriving mid-MEM_WAIT; no completion is awaited.
- Control outputs are combinational from the current state and inputs. Counters and state are registered.
- Signals used below:
  - lu = ex_memread_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs1_i) | (id_use_rs2_i & ex_rd_i==id_rs2_i)).
  - mw = mem_req_i & ~mem_ready_i.
- Control outputs in IDLE:
  - pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, mem_wb_bubble_o=1, id_ex_bubble_o=0, if_id_flush_o=0.
  - The pipeline is fully frozen.
- Control outputs in RUN or MEM_WAIT, checked in this priority order:
  1. Freeze, when mw=1: pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, mem_wb_bubble_o=1, id_ex_bubble_o=0, if_id_flush_o=0. lu and branch are ignored this cycle.
  2. Load-use, when lu=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, pipe_hold_o=0. if_id_flush_o=0 even if id_branch_taken_i=1, because the branch re-resolves next cycle with correct operands.
  3. Flush, when id_branch_taken_i=1: if_id_flush_o=1, pc_write_o=1, if_id_write_o=1.
  4. Otherwise: pc_write_o=1, if_id_write_o=1, all other outputs 0.
- FSM transitions:
  - IDLE -> RUN when start_i=1. The first advancing edge is the one after start_i is sampled high.
  - RUN -> MEM_WAIT when mw=1.
  - RUN -> IDLE when start_i=0 and mw=0.
  - MEM_WAIT -> RUN when mem_ready_i=1 and start_i=1.
  - MEM_WAIT -> IDLE when mem_ready_i=1 and start_i=0. An outstanding access always completes before IDLE is entered.
  - MEM_WAIT stays in MEM_WAIT while mem_ready_i=0.
  - When mem_ready_i=1 in MEM_WAIT, that cycle's outputs follow priorities 2–4.
- Counters (increment on the clock edge ending a qualifying cycle, only in RUN or MEM_WAIT):
  - stall_cnt_o +1 on each priority-2 cycle.
  - flush_cnt_o +1 on each priority-3 cycle.
  - wait_cnt_o +1 on each priority-1 cycle.
  - Each counter saturates at 2^CNT_W-1 (no wrap).
  - No counter changes in IDLE.
- A single-cycle memory (mem_ready_i tied to 1) never enters MEM_WAIT. In that case the block behaves as a plain hazard unit.

Test Plan:
- Reset then start: rst_i=1 for 2 cycles, then start_i=1 -> state_o goes 0 then 1 one edge later; pc_write_o=0 in IDLE and 1 in RUN; all counters are 0.
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 for 1 cycle -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; stall_cnt_o=1. Repeat with ex_rd_i=0 -> no stall.
- Taken branch: id_branch_taken_i=1 with lu=0 -> if_id_flush_o=1; flush_cnt_o increments by 1. Same input with lu=1 -> flush suppressed, stall_cnt_o increments by 1, flush_cnt_o unchanged.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> state_o reads 1,2,2,2,1; pipe_hold_o=1 and mem_wb_bubble_o=1 on the 3 waiting cycles; wait_cnt_o=3. A concurrent lu=1 during the wait does not increment stall_cnt_o.
- Stop mid-wait: start_i drops to 0 during MEM_WAIT -> state stays 2 until mem_ready_i=1, then becomes 0 (IDLE); pc_write_o=0 from then on.
- Saturation and reset mid-op: with CNT_W=2, 5 stall cycles -> stall_cnt_o=3. rst_i=1 during MEM_WAIT -> state_o=0 and all counters 0 on the next edge.
